// File: rtl/cpu_axi_pkg.sv
// Shared AXI3 constants, transfer-size encodings and the write-bridge
// state encoding used by the store-to-AXI write path.
package cpu_axi_pkg;

  // AXI3 burst / response encodings
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AXI transfer size encodings (log2 of bytes per beat)
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // Bridge state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_WAIT_B = 2'd2;
  localparam logic [1:0] ST_LOCAL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SEND   = ST_SEND,
    S_WAIT_B = ST_WAIT_B,
    S_LOCAL  = ST_LOCAL
  } bridge_state_e;

  // Any response other than OKAY is reported as a bus error.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_wstrb_size_decode.sv
// Maps a store's byte enables and byte address onto the AXI transfer size
// and the size-aligned address presented on AW. Purely combinational.
module axi_wstrb_size_decode
  import cpu_axi_pkg::*;
(
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  output logic [2:0]  size,
  output logic [31:0] aligned_addr
);

  // Single-byte and aligned halfword enables map to narrow transfers;
  // every other pattern (including sparse ones) goes out as a full word.
  always_comb begin
    size         = SIZE_WORD;
    aligned_addr = {addr[31:2], 2'b00};
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        size         = SIZE_BYTE;
        aligned_addr = addr;
      end
      4'b0011, 4'b1100: begin
        size         = SIZE_HALF;
        aligned_addr = {addr[31:1], 1'b0};
      end
      default: begin
        size         = SIZE_WORD;
        aligned_addr = {addr[31:2], 2'b00};
      end
    endcase
  end

endmodule

// File: rtl/store_axi_write_bridge.sv
// Store-buffer to AXI3 write bridge. Takes one store per handshake, issues
// it as a single-beat write with independent AW/W handshakes, waits for the
// B response and pulses done so the store buffer can advance. Stores with
// no byte enabled complete locally without touching the bus.
module store_axi_write_bridge
  import cpu_axi_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
  input  logic            clk,
  input  logic            reset,
  // store buffer side
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_wen,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            done,
  output logic            idle,
  output logic            bus_error,
  input  logic            err_clear,
  // AXI3 write address channel
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  // AXI3 write data channel
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI3 write response channel
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  bridge_state_e state_r, state_nxt_s;

  logic        aw_pend_r, aw_pend_nxt_s;
  logic        w_pend_r,  w_pend_nxt_s;
  logic        accept_s;
  logic        done_s;
  logic        set_err_s;
  logic        bus_error_r;

  logic [3:0]  wen_r;
  logic [31:0] addr_r;
  logic [2:0]  size_r;
  logic [31:0] wdata_r;

  logic [2:0]  dec_size_s;
  logic [31:0] dec_addr_s;

  // Only one write is ever outstanding, so the response ID carries no
  // information the bridge needs.
  logic        unused_bid_s;
  assign unused_bid_s = ^bid;

  axi_wstrb_size_decode u_decode (
    .wen          (req_wen),
    .addr         (req_addr),
    .size         (dec_size_s),
    .aligned_addr (dec_addr_s)
  );

  // Next-state, pending-flag and completion logic
  always_comb begin
    state_nxt_s   = state_r;
    aw_pend_nxt_s = aw_pend_r;
    w_pend_nxt_s  = w_pend_r;
    accept_s      = 1'b0;
    done_s        = 1'b0;
    set_err_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          if (req_wen != 4'b0000) begin
            accept_s      = 1'b1;
            aw_pend_nxt_s = 1'b1;
            w_pend_nxt_s  = 1'b1;
            state_nxt_s   = S_SEND;
          end else begin
            state_nxt_s   = S_LOCAL;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SEND: begin
        if (aw_pend_r && awready) begin
          aw_pend_nxt_s = 1'b0;
        end else begin
          aw_pend_nxt_s = aw_pend_r;
        end
        if (w_pend_r && wready) begin
          w_pend_nxt_s = 1'b0;
        end else begin
          w_pend_nxt_s = w_pend_r;
        end
        // Leave as soon as both channels have handshaken, whichever was last.
        if (!aw_pend_nxt_s && !w_pend_nxt_s) begin
          state_nxt_s = S_WAIT_B;
        end else begin
          state_nxt_s = S_SEND;
        end
      end
      S_WAIT_B: begin
        if (bvalid) begin
          done_s      = 1'b1;
          set_err_s   = resp_is_error(bresp);
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT_B;
        end
      end
      S_LOCAL: begin
        done_s      = 1'b1;
        state_nxt_s = S_IDLE;
      end
      default: begin
        aw_pend_nxt_s = 1'b0;
        w_pend_nxt_s  = 1'b0;
        state_nxt_s   = S_IDLE;
      end
    endcase
  end

  // State, pending flags and the captured store; reset drops any in-flight store
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      aw_pend_r <= 1'b0;
      w_pend_r  <= 1'b0;
      wen_r     <= 4'b0000;
      addr_r    <= 32'h0000_0000;
      size_r    <= 3'd0;
      wdata_r   <= 32'h0000_0000;
    end else begin
      state_r   <= state_nxt_s;
      aw_pend_r <= aw_pend_nxt_s;
      w_pend_r  <= w_pend_nxt_s;
      if (accept_s) begin
        wen_r   <= req_wen;
        addr_r  <= dec_addr_s;
        size_r  <= dec_size_s;
        wdata_r <= req_wdata;
      end
    end
  end

  // Sticky bus error: a new error response wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_error_r <= 1'b0;
    end else if (set_err_s) begin
      bus_error_r <= 1'b1;
    end else if (err_clear) begin
      bus_error_r <= 1'b0;
    end
  end

  assign req_ready = (state_r == S_IDLE);
  assign idle      = (state_r == S_IDLE);
  assign done      = done_s;
  assign bus_error = bus_error_r;

  assign awid      = AXI_ID;
  assign awaddr    = addr_r;
  assign awlen     = 4'd0;
  assign awsize    = size_r;
  assign awburst   = AXI_BURST_INCR;
  assign awlock    = 2'b00;
  assign awcache   = 4'b0000;
  assign awprot    = 3'b000;
  assign awvalid   = (state_r == S_SEND) && aw_pend_r;

  assign wid       = AXI_ID;
  assign wdata     = wdata_r;
  assign wstrb     = wen_r;
  assign wlast     = 1'b1;
  assign wvalid    = (state_r == S_SEND) && w_pend_r;

  assign bready    = (state_r == S_WAIT_B);

endmodule
